// File: rtl/mapreduce_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mapreduce_pkg                                                    |
// | Shared point geometry and mapper-ID sizing for the map units.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mapreduce_pkg;

    localparam int c_NUM_MAPPERS = 4;
    localparam int c_DIMENSION   = 2;
    localparam int c_PRECISION   = 16;
    localparam int c_DATA_WIDTH  = c_DIMENSION * c_PRECISION;
    localparam int c_ID_BITS     = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter                                                       |
// | Round-robin one-of-N selector; pointer moves to one past winner. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter
    import mapreduce_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_MAPPERS,
    parameter int ID_BITS = c_ID_BITS
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_BITS-1:0] winner
);

    logic [ID_BITS-1:0] r_ptr;
    logic               w_found;
    int                 w_idx;

    // Scan starting at the pointer; the first set request wins.
    always_comb begin
        gnt     = '0;
        winner  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (enable && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                winner     = w_idx[ID_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (winner == ID_BITS'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/map_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | map_dispatcher                                                   |
// | Queues mapper requests in arrival order and hands each one the   |
// | next point of the input stream.                                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module map_dispatcher
    import mapreduce_pkg::*;
#(
    parameter int NUM_MAPPERS = c_NUM_MAPPERS,
    parameter int DIMENSION   = c_DIMENSION,
    parameter int PRECISION   = c_PRECISION,
    parameter int DATA_WIDTH  = DIMENSION * PRECISION,
    parameter int ID_BITS     = c_ID_BITS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_MAPPERS-1:0] request,
    output logic [NUM_MAPPERS-1:0] queued,
    output logic [NUM_MAPPERS-1:0] grant,
    output logic [DATA_WIDTH-1:0]  value_data_out,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [31:0]            points_sent,
    output logic                   stream_done
);

    logic [ID_BITS-1:0]     r_fifo [NUM_MAPPERS];
    logic [ID_BITS-1:0]     r_wr_ptr;
    logic [ID_BITS-1:0]     r_rd_ptr;
    logic [ID_BITS:0]       r_count;
    logic [NUM_MAPPERS-1:0] r_pending;
    logic [NUM_MAPPERS-1:0] r_queued;
    logic [NUM_MAPPERS-1:0] r_grant;
    logic [DATA_WIDTH-1:0]  r_value;
    logic [31:0]            r_points;
    logic                   r_done;

    logic [NUM_MAPPERS-1:0] w_eligible;
    logic [NUM_MAPPERS-1:0] w_sel_gnt;
    logic [ID_BITS-1:0]     w_sel_id;
    logic                   w_push;
    logic                   w_pop;
    logic [ID_BITS-1:0]     w_head;
    logic [NUM_MAPPERS-1:0] w_pop_mask;

    function automatic logic [ID_BITS-1:0] f_next_ptr(input logic [ID_BITS-1:0] p);
        return (p == ID_BITS'(NUM_MAPPERS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_eligible = request & ~r_pending;

    rr_arbiter #(
        .NUM_REQ (NUM_MAPPERS),
        .ID_BITS (ID_BITS)
    ) u_rr_arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (w_eligible),
        .enable  (reset_n),
        .gnt     (w_sel_gnt),
        .winner  (w_sel_id)
    );

    // Dispatch only from IDs already registered in the FIFO, so a fresh
    // selection is never granted in its own cycle.
    assign w_push   = |w_sel_gnt;
    assign w_pop    = reset_n && (r_count != '0) && in_valid && !r_done;
    assign w_head   = r_fifo[r_rd_ptr];
    assign in_ready = w_pop;

    always_comb begin
        w_pop_mask = '0;
        if (w_pop) begin
            w_pop_mask[w_head] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel_id;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_queued  <= '0;
            r_grant   <= '0;
            r_value   <= '0;
            r_points  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_queued  <= w_sel_gnt;
            r_grant   <= w_pop_mask;
            r_pending <= (r_pending | w_sel_gnt) & ~w_pop_mask;
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
                r_value  <= in_data;
                r_points <= r_points + 32'd1;
                if (in_last) begin
                    r_done <= 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign queued         = r_queued;
    assign grant          = r_grant;
    assign value_data_out = r_value;
    assign points_sent    = r_points;
    assign stream_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_map_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_map_dispatcher                                                |
// | Directed-vector bench for map_dispatcher.                        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_map_dispatcher;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic [3:0]  request  = '0;
    logic [31:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic [3:0]  queued;
    logic [3:0]  grant;
    logic [31:0] value_data_out;
    logic        in_ready;
    logic [31:0] points_sent;
    logic        stream_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] d_pts [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

    map_dispatcher u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .request        (request),
        .queued         (queued),
        .grant          (grant),
        .value_data_out (value_data_out),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .points_sent    (points_sent),
        .stream_done    (stream_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        request  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        #1;
        check("rst_queued", 64'(queued), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_value", 64'(value_data_out), 64'd0);
        check("rst_points", 64'(points_sent), 64'd0);
        check("rst_done", 64'(stream_done), 64'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        do_reset();

        // Single requester: queued at T+1, grant at T+2
        tick();
        request  = 4'b0001;
        in_data  = 32'h0001_0002;
        in_valid = 1'b1;
        #1;
        check("s_ready_empty", 64'(in_ready), 64'd0);
        tick();
        #1;
        check("s_queued", 64'(queued), 64'b0001);
        check("s_grant_early", 64'(grant), 64'd0);
        check("s_ready", 64'(in_ready), 64'd1);
        tick();
        request  = 4'b0000;
        in_valid = 1'b0;
        #1;
        check("s_grant", 64'(grant), 64'b0001);
        check("s_value", 64'(value_data_out), 64'h0001_0002);
        check("s_points", 64'(points_sent), 64'd1);
        tick();
        #1;
        check("s_grant_once", 64'(grant), 64'd0);

        // Fairness: all four request, queued in order 0..3
        do_reset();
        request = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("fair_queued", 64'(queued), 64'(4'b0001 << i));
        end
        tick();
        request = 4'b0000;
        #1;
        check("fair_no_repeat", 64'(queued), 64'd0);

        // Stall for 10 cycles, then four points on consecutive cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            check("stall_grant", 64'(grant), 64'd0);
            check("stall_ready", 64'(in_ready), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            in_data  = d_pts[i];
            in_valid = 1'b1;
            #1;
            check("burst_ready", 64'(in_ready), 64'd1);
            if (i == 0) begin
                check("burst_grant0", 64'(grant), 64'd0);
            end else begin
                check("burst_grant", 64'(grant), 64'(4'b0001 << (i - 1)));
                check("burst_value", 64'(value_data_out), 64'(d_pts[i-1]));
            end
        end
        tick();
        in_valid = 1'b0;
        #1;
        check("burst_grant_last", 64'(grant), 64'b1000);
        check("burst_value_last", 64'(value_data_out), 64'(d_pts[3]));
        check("burst_points", 64'(points_sent), 64'd4);
        check("burst_ready_empty", 64'(in_ready), 64'd0);

        // Order: queue 2 then 0; grants follow queued order
        tick();
        request = 4'b0100;
        tick();
        request = 4'b0001;
        #1;
        check("ord_queued2", 64'(queued), 64'b0100);
        tick();
        request = 4'b0000;
        #1;
        check("ord_queued0", 64'(queued), 64'b0001);
        tick();
        in_data  = 32'h1111_2222;
        in_valid = 1'b1;
        tick();
        in_data = 32'h3333_4444;
        #1;
        check("ord_grant2", 64'(grant), 64'b0100);
        check("ord_value_a", 64'(value_data_out), 64'h1111_2222);
        tick();
        in_valid = 1'b0;
        #1;
        check("ord_grant0", 64'(grant), 64'b0001);
        check("ord_value_b", 64'(value_data_out), 64'h3333_4444);
        check("ord_points", 64'(points_sent), 64'd6);

        // End of stream: third point is last, fourth refused
        do_reset();
        request = 4'b1111;
        repeat (4) tick();
        request  = 4'b0000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = d_pts[i];
            in_last = (i == 2);
            #1;
            check("end_ready", 64'(in_ready), 64'd1);
            if (i > 0) begin
                check("end_grant", 64'(grant), 64'(4'b0001 << (i - 1)));
                check("end_value", 64'(value_data_out), 64'(d_pts[i-1]));
            end
            tick();
        end
        in_data = d_pts[3];
        in_last = 1'b0;
        request = 4'b0001;
        #1;
        check("end_grant_last", 64'(grant), 64'b0100);
        check("end_value_last", 64'(value_data_out), 64'(d_pts[2]));
        check("end_done", 64'(stream_done), 64'd1);
        check("end_points", 64'(points_sent), 64'd3);
        check("end_ready_low", 64'(in_ready), 64'd0);
        tick();
        request = 4'b0000;
        #1;
        check("end_no_grant", 64'(grant), 64'd0);
        check("end_points_hold", 64'(points_sent), 64'd3);
        check("end_value_hold", 64'(value_data_out), 64'(d_pts[2]));
        check("end_queue_cont", 64'(queued), 64'b0001);
        in_valid = 1'b0;

        // Reset with three IDs pending
        do_reset();
        request = 4'b0111;
        repeat (3) tick();
        request = 4'b0000;
        tick();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h5555_AAAA;
        #1;
        check("mid_ready_rst", 64'(in_ready), 64'd0);
        tick();
        #1;
        check("mid_queued", 64'(queued), 64'd0);
        check("mid_grant", 64'(grant), 64'd0);
        check("mid_points", 64'(points_sent), 64'd0);
        check("mid_done", 64'(stream_done), 64'd0);
        reset_n = 1'b1;
        #1;
        check("mid_fifo_empty", 64'(in_ready), 64'd0);
        request = 4'b0100;
        tick();
        request = 4'b0000;
        #1;
        check("mid_requeue", 64'(queued), 64'b0100);
        check("mid_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("mid_grant2", 64'(grant), 64'b0100);
        check("mid_value", 64'(value_data_out), 64'h5555_AAAA);
        check("mid_points1", 64'(points_sent), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
